// File: rtl/instr_exec_ctrl_pkg.sv
// Shared definitions for the instruction execution controller: fetch-side
// widths, instruction field positions, opcodes and FSM state encodings.
package instr_exec_ctrl_pkg;

  localparam int INSTR_LEN = 16;
  localparam int IADDR_LEN = 10;
  localparam int N_STAGES  = 3;
  localparam int OPND_W    = 12;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int OPND_MSB = 11;
  localparam int OPND_LSB = 0;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_EXEC    = 4'd1;
  localparam logic [3:0] OP_SET_CNT = 4'd2;
  localparam logic [3:0] OP_JMP     = 4'd3;
  localparam logic [3:0] OP_JNZ     = 4'd4;
  localparam logic [3:0] OP_YIELD   = 4'd5;

  typedef enum logic [1:0] {
    ST_WAIT_LOAD = 2'd0,
    ST_RUN       = 2'd1,
    ST_INV       = 2'd2,
    ST_SWITCH    = 2'd3
  } state_t;

  // Width of a thread index: MSB(n-1)+1, never less than one bit.
  function automatic int thread_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/instr_exec_ctrl_if.sv
// Fetch-unit and compute-unit signals seen by the execution controller.
// master = the controller, slave = the fetch/compute side.
interface instr_exec_ctrl_if #(
  parameter int THREAD_W = 4
);
  import instr_exec_ctrl_pkg::*;

  logic [INSTR_LEN-1:0] instruction;
  logic [N_STAGES-1:0]  stage_allow;
  logic                 thread_almost_switched;
  logic [THREAD_W-1:0]  thread_num;
  logic                 INVALIDATE;
  logic                 INSTR_WAIT;
  logic                 EXECUTED;
  logic                 NEXT_THREAD;
  logic                 JUMP;
  logic [IADDR_LEN-1:0] jump_addr;
  logic                 unit_op_valid;
  logic [OPND_W-1:0]    unit_op;
  logic                 unit_op_ready;
  logic                 err;

  modport master (
    input  instruction, stage_allow, thread_almost_switched, thread_num, unit_op_ready,
    output INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr,
           unit_op_valid, unit_op, err
  );

  modport slave (
    output instruction, stage_allow, thread_almost_switched, thread_num, unit_op_ready,
    input  INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr,
           unit_op_valid, unit_op, err
  );

endinterface

// File: rtl/instr_exec_ctrl_thread_counters.sv
// Per-thread loop counters: small distributed RAM, asynchronous read,
// one synchronous write per cycle. Contents are deliberately not reset;
// programs initialise their counter with SET_CNT before using JNZ.
module instr_exec_ctrl_thread_counters #(
  parameter int N_THREADS = 16,
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  wdata,
  output logic [CNT_W-1:0]  rdata
);

  logic [CNT_W-1:0] mem [N_THREADS];

  // Single write port, same address as the read port (the running thread).
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/instr_exec_ctrl.sv
// Execution/retire controller for the sha512unit CPU. Decodes the fetched
// instruction in the same cycle, drives the fetch-unit strobes, keeps the
// per-thread loop counters and hands EXEC operands to the compute unit.
//
//  state     | meaning
//  WAIT_LOAD | waiting for the next thread's first instruction
//  RUN       | decoding and retiring instructions
//  INV       | reserved 2-cycle invalidate variant, unreachable (sets err)
//  SWITCH    | one cycle of NEXT_THREAD (with JUMP for a jump)
module instr_exec_ctrl
  import instr_exec_ctrl_pkg::*;
#(
  parameter int N_CORES   = 4,
  parameter int N_THREADS = 4 * N_CORES,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  instr_exec_ctrl_if.master bus
);

  localparam int THREAD_W = thread_w(N_THREADS);

  state_t               state;
  logic                 instr_valid_q;
  logic                 hold_q;
  logic [INSTR_LEN-1:0] held_instr_q;
  logic                 sw_jump_q;
  logic [IADDR_LEN-1:0] jump_addr_q;
  logic                 inv_q;
  logic                 err_q;

  logic [INSTR_LEN-1:0] cur_instr;
  logic [3:0]           opcode;
  logic [OPND_W-1:0]    operand;
  logic                 instr_valid;
  logic [CNT_W-1:0]     cnt_rd;
  logic [CNT_W-1:0]     cnt_wdata;
  logic                 cnt_we;

  logic executed, instr_wait, invalidate, next_thread, jump, uop_valid;
  logic take_jump, take_yield, illegal, stall;

  // A stalled EXEC is replayed from a local copy so its operand stays stable.
  assign cur_instr   = hold_q ? held_instr_q : bus.instruction;
  assign opcode      = cur_instr[OPC_MSB:OPC_LSB];
  assign operand     = cur_instr[OPND_MSB:OPND_LSB];
  assign instr_valid = (instr_valid_q | hold_q) && (state == ST_RUN);

  instr_exec_ctrl_thread_counters #(
    .N_THREADS (N_THREADS),
    .ADDR_W    (THREAD_W),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .we    (cnt_we),
    .addr  (bus.thread_num[THREAD_W-1:0]),
    .wdata (cnt_wdata),
    .rdata (cnt_rd)
  );

  // Same-cycle decode of the current instruction into fetch/unit strobes.
  always_comb begin
    executed    = 1'b0;
    instr_wait  = 1'b0;
    invalidate  = 1'b0;
    next_thread = 1'b0;
    jump        = 1'b0;
    uop_valid   = 1'b0;
    take_jump   = 1'b0;
    take_yield  = 1'b0;
    illegal     = 1'b0;
    stall       = 1'b0;
    cnt_we      = 1'b0;
    cnt_wdata   = '0;
    case (state)
      ST_RUN: begin
        if (instr_valid) begin
          case (opcode)
            OP_NOP: executed = 1'b1;
            OP_EXEC: begin
              uop_valid = 1'b1;
              if (bus.unit_op_ready) begin
                executed = 1'b1;
              end else begin
                instr_wait = 1'b1;
                stall      = 1'b1;
              end
            end
            OP_SET_CNT: begin
              executed  = 1'b1;
              cnt_we    = 1'b1;
              cnt_wdata = operand[CNT_W-1:0];
            end
            OP_JMP: begin
              invalidate = 1'b1;
              take_jump  = 1'b1;
            end
            OP_JNZ: begin
              if (cnt_rd != '0) begin
                invalidate = 1'b1;
                take_jump  = 1'b1;
                cnt_we     = 1'b1;
                cnt_wdata  = cnt_rd - 1'b1;
              end else begin
                executed = 1'b1;
              end
            end
            OP_YIELD: begin
              invalidate = 1'b1;
              take_yield = 1'b1;
            end
            default: begin
              executed = 1'b1;
              illegal  = 1'b1;
            end
          endcase
        end
      end
      ST_SWITCH: begin
        // A reset arriving in this cycle cancels the thread switch.
        if (!RST) begin
          next_thread = 1'b1;
          jump        = sw_jump_q;
          executed    = !sw_jump_q;
        end
      end
      default: ;
    endcase
  end

  // Sequencing FSM plus stall capture, jump target, and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_WAIT_LOAD;
      instr_valid_q <= 1'b0;
      hold_q        <= 1'b0;
      held_instr_q  <= '0;
      sw_jump_q     <= 1'b0;
      jump_addr_q   <= '0;
      inv_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      instr_valid_q <= bus.stage_allow[0];
      hold_q        <= stall;
      if (stall) held_instr_q <= cur_instr;
      inv_q <= invalidate;
      if (illegal || (state == ST_INV) || (invalidate && (inv_q || instr_wait)) ||
          (jump && !next_thread)) begin
        err_q <= 1'b1;
      end
      case (state)
        ST_WAIT_LOAD: begin
          if (bus.thread_almost_switched) state <= ST_RUN;
        end
        ST_RUN: begin
          if (take_jump) begin
            state       <= ST_SWITCH;
            sw_jump_q   <= 1'b1;
            jump_addr_q <= operand[IADDR_LEN-1:0];
          end else if (take_yield) begin
            state     <= ST_SWITCH;
            sw_jump_q <= 1'b0;
          end
        end
        ST_SWITCH: state <= ST_WAIT_LOAD;
        default:   state <= ST_WAIT_LOAD;
      endcase
    end
  end

  assign bus.EXECUTED      = executed;
  assign bus.INSTR_WAIT    = instr_wait;
  assign bus.INVALIDATE    = invalidate;
  assign bus.NEXT_THREAD   = next_thread;
  assign bus.JUMP          = jump;
  assign bus.jump_addr     = jump_addr_q;
  assign bus.unit_op_valid = uop_valid;
  assign bus.unit_op       = operand;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// Scoreboard bench for instr_exec_ctrl: stimulus pushes the expected strobe
// pattern for every cycle in which the controller should show activity; a
// negedge monitor pops and compares whenever any strobe is asserted.
module tb_instr_exec_ctrl;
  import instr_exec_ctrl_pkg::*;

  typedef struct packed {
    logic        ex;
    logic        iw;
    logic        inv;
    logic        nt;
    logic        jmp;
    logic        uv;
    logic [11:0] uop;
    logic [9:0]  ja;
  } obs_t;

  typedef struct {
    obs_t  o;
    string nm;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   tests_run = 0;
  int   failures  = 0;
  exp_t exp_q[$];
  logic [9:0] exp_ja = '0;

  always #5 CLK = ~CLK;

  instr_exec_ctrl_if #(.THREAD_W(4)) bus ();

  instr_exec_ctrl #(
    .N_CORES   (4),
    .N_THREADS (16),
    .CNT_W     (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Monitor: every cycle with activity must match the next expected entry.
  always @(negedge CLK) begin
    obs_t a;
    exp_t e;
    if (bus.EXECUTED || bus.INSTR_WAIT || bus.INVALIDATE || bus.NEXT_THREAD ||
        bus.JUMP || bus.unit_op_valid) begin
      a.ex  = bus.EXECUTED;
      a.iw  = bus.INSTR_WAIT;
      a.inv = bus.INVALIDATE;
      a.nt  = bus.NEXT_THREAD;
      a.jmp = bus.JUMP;
      a.uv  = bus.unit_op_valid;
      a.uop = bus.unit_op_valid ? bus.unit_op : 12'h000;
      a.ja  = bus.jump_addr;
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe @%0t: got ex/iw/inv/nt/jmp/uv=%06b uop=%03h ja=%03h, required no activity",
                 $time, {a.ex, a.iw, a.inv, a.nt, a.jmp, a.uv}, a.uop, a.ja);
      end else begin
        e = exp_q.pop_front();
        if (a !== e.o) begin
          failures++;
          $display("FAIL %s @%0t: got ex/iw/inv/nt/jmp/uv=%06b uop=%03h ja=%03h, required %06b uop=%03h ja=%03h",
                   e.nm, $time, {a.ex, a.iw, a.inv, a.nt, a.jmp, a.uv}, a.uop, a.ja,
                   {e.o.ex, e.o.iw, e.o.inv, e.o.nt, e.o.jmp, e.o.uv}, e.o.uop, e.o.ja);
        end
      end
    end
  end

  function automatic obs_t mk(input bit ex, iw, inv, nt, jmp, uv, input logic [11:0] uop);
    obs_t o;
    o.ex  = ex;
    o.iw  = iw;
    o.inv = inv;
    o.nt  = nt;
    o.jmp = jmp;
    o.uv  = uv;
    o.uop = uop;
    o.ja  = exp_ja;
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string nm, input obs_t o);
    exp_t e;
    e.o  = o;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic idle(input int n);
    bus.stage_allow = 3'b000;
    bus.instruction = 16'h0000;
    repeat (n) tick();
  endtask

  // Announce the next thread; its first instruction is presented next cycle.
  task automatic start_thread(input logic [3:0] tn);
    bus.thread_num             = tn;
    bus.thread_almost_switched = 1'b1;
    bus.stage_allow            = 3'b001;
    bus.instruction            = 16'h0000;
    tick();
    bus.thread_almost_switched = 1'b0;
  endtask

  // Present one instruction; 'more' says whether another follows next cycle.
  task automatic instr_cycle(input string nm, input logic [15:0] ins, input bit more, input obs_t o);
    bus.instruction = ins;
    bus.stage_allow = more ? 3'b001 : 3'b000;
    push(nm, o);
    tick();
  endtask

  task automatic switch_cycle(input string nm, input bit is_jump, input logic [9:0] target);
    if (is_jump) exp_ja = target;
    bus.stage_allow = 3'b000;
    bus.instruction = 16'h0000;
    push(nm, mk(!is_jump, 0, 0, 1, is_jump, 0, 12'h000));
    tick();
  endtask

  initial begin
    RST                        = 1'b1;
    bus.instruction            = 16'h0000;
    bus.stage_allow            = 3'b000;
    bus.thread_almost_switched = 1'b0;
    bus.thread_num             = 4'd0;
    bus.unit_op_ready          = 1'b0;
    repeat (3) tick();
    check("reset_strobes", {25'd0, bus.INVALIDATE, bus.INSTR_WAIT, bus.EXECUTED,
                            bus.NEXT_THREAD, bus.JUMP, bus.unit_op_valid, bus.err}, 32'd0);
    check("reset_jump_addr", {22'd0, bus.jump_addr}, 32'd0);
    RST = 1'b0;
    // WAIT_LOAD must ignore loaded instructions until the thread switch.
    bus.stage_allow = 3'b001;
    repeat (2) tick();

    // 1: three back-to-back retires
    start_thread(4'd2);
    instr_cycle("t1_nop0", 16'h0000, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t1_nop1", 16'h0000, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t1_setcnt3", 16'h2003, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));

    // 2: EXEC stalled four cycles, then accepted
    bus.unit_op_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      instr_cycle("t2_exec_stall", 16'h10A5, 0, mk(0, 1, 0, 0, 0, 1, 12'h0A5));
    bus.unit_op_ready = 1'b1;
    instr_cycle("t2_exec_ready", 16'h10A5, 1, mk(1, 0, 0, 0, 0, 1, 12'h0A5));

    // 3: JMP 150, then silence until the next thread_almost_switched
    instr_cycle("t3_jmp_inv", 16'h3096, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t3_jmp_switch", 1, 10'd150);
    idle(4);

    // 4: SET_CNT 2 then JNZ taken, taken, not taken, not taken (no wrap)
    start_thread(4'd2);
    instr_cycle("t4_setcnt2", 16'h2002, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t4_jnz1_inv", 16'h4040, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t4_jnz1_switch", 1, 10'h040);
    idle(2);
    start_thread(4'd2);
    instr_cycle("t4_jnz2_inv", 16'h4041, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t4_jnz2_switch", 1, 10'h041);
    idle(2);
    start_thread(4'd2);
    instr_cycle("t4_jnz3_fall", 16'h4042, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t4_jnz4_nowrap", 16'h4043, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t4_yield_inv", 16'h5000, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t4_yield_switch", 0, 10'h000);
    idle(2);

    // 5: thread 5 counter survives thread 6 SET_CNT 7
    start_thread(4'd5);
    instr_cycle("t5_setcnt1", 16'h2001, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t5_yield_inv", 16'h5000, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t5_yield_switch", 0, 10'h000);
    idle(2);
    start_thread(4'd6);
    instr_cycle("t5_t6_setcnt7", 16'h2007, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    instr_cycle("t5_t6_yield_inv", 16'h5000, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t5_t6_yield_switch", 0, 10'h000);
    idle(2);
    start_thread(4'd5);
    instr_cycle("t5_jnz_taken", 16'h4055, 0, mk(0, 0, 1, 0, 0, 0, 12'h000));
    switch_cycle("t5_jnz_switch", 1, 10'h055);
    idle(2);
    start_thread(4'd5);
    instr_cycle("t5_jnz_fall", 16'h4056, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    check("err_clear_before_illegal", {31'd0, bus.err}, 32'd0);

    // 6: illegal opcode retires as NOP and sets err; reset during a stall
    instr_cycle("t6_illegal", 16'hF123, 1, mk(1, 0, 0, 0, 0, 0, 12'h000));
    bus.unit_op_ready = 1'b0;
    instr_cycle("t6_exec_stall", 16'h107E, 0, mk(0, 1, 0, 0, 0, 1, 12'h07E));
    check("err_sticky_after_illegal", {31'd0, bus.err}, 32'd1);
    RST = 1'b1;
    push("t6_stall_in_rst", mk(0, 1, 0, 0, 0, 1, 12'h07E));
    tick();
    RST    = 1'b0;
    exp_ja = '0;
    check("rst_drops_unit_op_valid", {31'd0, bus.unit_op_valid}, 32'd0);
    check("rst_drops_instr_wait", {31'd0, bus.INSTR_WAIT}, 32'd0);
    check("rst_clears_err", {31'd0, bus.err}, 32'd0);
    check("rst_clears_jump_addr", {22'd0, bus.jump_addr}, 32'd0);
    // Back in WAIT_LOAD: loaded instructions must not retire.
    bus.instruction = 16'h0000;
    bus.stage_allow = 3'b001;
    repeat (3) tick();
    idle(2);

    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL expected_queue_drained: got %0d pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
